// File: rtl/lsu_byte_seq.sv
// Byte-serial load/store sequencer: splits byte/half/word accesses into little-endian single-byte memory cycles.
// Optional LSU_MISALIGN_SPLIT_EN: misaligned half/word accesses run byte-by-byte instead of erroring.
module lsu_byte_seq #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read_rq,
  output logic              mem_write_rq,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        we_r;
  logic        uns_r;
  logic [1:0]  size_r;
  logic [1:0]  cnt;
  logic [1:0]  last;
  logic [31:0] wdata_r;
  logic [31:0] data_r;

  logic [1:0]  req_last;
  logic        req_err;
  logic [1:0]  cnt_nx;
  logic [31:0] ld_word;
  logic [31:0] ld_ext;

  always_comb begin
    case (req_size)
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  // Full-width end address so an access can never wrap past the top of memory.
  logic [32:0] end_addr;
  assign end_addr = {1'b0, req_addr} + {31'b0, req_last};
  assign req_err  = (req_size == 2'b11) || (end_addr > 33'(2 ** ADDR_W - 1));
`else
  assign req_err = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                || (req_addr[31:ADDR_W] != '0);
`endif

  assign cnt_nx = cnt + 2'd1;

  // Final load word includes the byte arriving in the current cycle.
  always_comb begin
    ld_word = data_r;
    ld_word[{cnt, 3'b000} +: 8] = mem_rdata;
    case (size_r)
      2'b00:   ld_ext = uns_r ? {24'b0, ld_word[7:0]}  : {{24{ld_word[7]}}, ld_word[7:0]};
      2'b01:   ld_ext = uns_r ? {16'b0, ld_word[15:0]} : {{16{ld_word[15]}}, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      we_r         <= 1'b0;
      uns_r        <= 1'b0;
      size_r       <= 2'b00;
      cnt          <= 2'd0;
      last         <= 2'd0;
      wdata_r      <= '0;
      data_r       <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      mem_read_rq  <= 1'b0;
      mem_write_rq <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_r      <= req_we;
            uns_r     <= req_unsigned;
            size_r    <= req_size;
            wdata_r   <= req_wdata;
            data_r    <= '0;
            cnt       <= 2'd0;
            last      <= req_last;
            req_ready <= 1'b0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state        <= ACCESS;
              mem_addr     <= req_addr[ADDR_W-1:0];
              mem_write_rq <= req_we;
              mem_read_rq  <= ~req_we;
              mem_wdata    <= req_we ? req_wdata[7:0] : 8'h00;
            end
          end
        end
        ACCESS: begin
          if (!we_r) data_r[{cnt, 3'b000} +: 8] <= mem_rdata;
          if (cnt == last) begin
            state        <= RESP;
            mem_read_rq  <= 1'b0;
            mem_write_rq <= 1'b0;
            mem_wdata    <= 8'h00;
            resp_valid   <= 1'b1;
            resp_err     <= 1'b0;
            resp_rdata   <= we_r ? 32'h0 : ld_ext;
          end else begin
            cnt       <= cnt_nx;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= we_r ? wdata_r[{cnt_nx, 3'b000} +: 8] : 8'h00;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Bench for lsu_byte_seq: vector table with strobe/latency checks, scoreboarded responses, stall and mid-op reset sequences.
module tb_lsu_byte_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read_rq;
  logic        mem_write_rq;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  lsu_byte_seq #(.ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read_rq(mem_read_rq), .mem_write_rq(mem_write_rq), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // 64 x 8 memory, preloaded with mem[i] = i.
  logic [7:0] mem [64];
  logic       mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
    end else if (mem_write_rq) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t       vecs [$];
  logic [32:0] sb_q [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata;
    return v;
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  // Response scoreboard: every transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 32'(resp_valid), 32'h0);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        check("resp_err", 32'(resp_err), 32'(e[32]));
        check("resp_rdata", resp_rdata, e[31:0]);
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_timeout", 32'(req_ready), 32'h1);
  endtask

  task automatic drive(input vec_t v);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
  endtask

  task automatic run_vec(input vec_t v);
    int n, lat, nst;
    n = nbytes(v.size);
    wait_ready();
    drive(v);
    sb_q.push_back({v.err, v.rdata});
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; nst = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_read_rq || mem_write_rq) begin
        check("strobe_kind", {30'b0, mem_write_rq, mem_read_rq}, v.we ? 32'h2 : 32'h1);
        check("mem_addr", 32'(mem_addr), 32'(6'(v.addr[5:0] + 6'(nst))));
        if (v.we) check("mem_wdata", 32'(mem_wdata), 32'(v.wdata[8*nst +: 8]));
        nst++;
      end
      if (resp_valid) lat = k;
    end
    check("latency", lat, v.err ? 1 : n + 1);
    check("strobe_count", nst, v.err ? 0 : n);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0B, 32'h0, 0, 32'hFFFFFFDE));
    vecs.push_back(mk(0, 2'b01, 1, 32'h0A, 32'h0, 0, 32'h0000DEAD));
    vecs.push_back(mk(0, 2'b10, 0, 32'h08, 32'h0, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 2'b01, 0, 32'h0A, 32'h0, 0, 32'hFFFFDEAD));
    vecs.push_back(mk(0, 2'b00, 1, 32'h08, 32'h0, 0, 32'h000000EF));
    vecs.push_back(mk(0, 2'b01, 0, 32'h08, 32'h0, 0, 32'hFFFFBEEF));
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs.push_back(mk(0, 2'b10, 0, 32'h09, 32'h0, 0, 32'h0CDEADBE));
`else
    vecs.push_back(mk(0, 2'b10, 0, 32'h09, 32'h0, 1, 32'h0));
`endif
    vecs.push_back(mk(0, 2'b11, 0, 32'h00, 32'h0, 1, 32'h0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h40, 32'h0, 1, 32'h0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h3F, 32'h0, 1, 32'h0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h20, 32'hAAAA1234, 0, 32'h0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h22, 32'hFFFFFF80, 0, 32'h0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h20, 32'h0, 0, 32'h00001234));
    vecs.push_back(mk(0, 2'b00, 0, 32'h22, 32'h0, 0, 32'hFFFFFF80));
    vecs.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h23801234));
    vecs.push_back(mk(0, 2'b10, 0, 32'h3C, 32'h0, 0, 32'h3F3E3D3C));
    vecs.push_back(mk(0, 2'b01, 1, 32'h3E, 32'h0, 0, 32'h00003F3E));
    vecs.push_back(mk(0, 2'b00, 0, 32'h80000000, 32'h0, 1, 32'h0));
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs.push_back(mk(1, 2'b10, 0, 32'h01, 32'hCAFEF00D, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h04, 32'h0, 0, 32'h000000CA));
`else
    vecs.push_back(mk(1, 2'b10, 0, 32'h01, 32'hCAFEF00D, 1, 32'h0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h04, 32'h0, 0, 32'h00000004));
`endif

    // Reset state.
    #12;
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_strobes", {30'b0, mem_write_rq, mem_read_rq}, 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mem_clr = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Response stall: output held, new requests ignored until transfer.
    begin
      int k;
      wait_ready();
      drive(mk(0, 2'b10, 0, 32'h08, 32'h0, 0, 32'h0));
      sb_q.push_back({1'b0, 32'hDEADBEEF});
      resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      k = 0;
      @(negedge clk);
      while (!resp_valid && k < 10) begin
        @(negedge clk);
        k++;
      end
      check("stall_resp_seen", 32'(resp_valid), 32'h1);
      drive(mk(1, 2'b00, 0, 32'h00, 32'h00000055, 0, 32'h0));
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("stall_resp_valid", 32'(resp_valid), 32'h1);
        check("stall_resp_rdata", resp_rdata, 32'hDEADBEEF);
        check("stall_req_ready", 32'(req_ready), 32'h0);
        check("stall_no_write", 32'(mem_write_rq), 32'h0);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_mem0_untouched", 32'(mem[0]), 32'h0);
      check("stall_sb_drained", sb_q.size(), 0);
    end

    // Reset after two bytes of a word store.
    wait_ready();
    drive(mk(1, 2'b10, 0, 32'h10, 32'h11223344, 0, 32'h0));
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("mid_write_active", 32'(mem_write_rq), 32'h1);
    check("mid_write_addr", 32'(mem_addr), 32'h12);
    rst = 1'b1;
    #1;
    check("mid_rst_strobes", {30'b0, mem_write_rq, mem_read_rq}, 32'h0);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      check("mid_rst_no_resp", seen, 0);
      check("mid_rst_req_ready", 32'(req_ready), 32'h1);
    end
    run_vec(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h13123344));
    run_vec(mk(0, 2'b00, 1, 32'h12, 32'h0, 0, 32'h00000012));

    repeat (3) @(negedge clk);
    check("sb_final_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
